// File: rtl/cla_addsub_pipe_pkg.sv
// Op encodings and saturation bounds shared by the pipelined CLA add/sub unit.
package cla_pkg;

   typedef enum logic [1:0] {
      OP_ADD     = 2'b00,
      OP_SUB     = 2'b01,
      OP_ADD_SAT = 2'b10,
      OP_SUB_SAT = 2'b11
   } op_e;

   localparam int unsigned MAX_WIDTH = 64;

   // Largest positive two's-complement value of the given width.
   function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned width);
      return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
   endfunction

   // Most negative two's-complement value of the given width.
   function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned width);
      return MAX_WIDTH'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result stream for cla_addsub_pipe: valid/ready in, valid/ready out.
interface cla_addsub_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovfl;
   logic             sat_flag;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, sum, cout, ovfl, sat_flag
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, sum, cout, ovfl, sat_flag
   );
endinterface

// File: rtl/cla_addsub_pipe_group.sv
// GROUP-bit carry-lookahead slice: local sum plus group propagate/generate.
module cla_group #(
   parameter int unsigned GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             p_out,
   output logic             g_out
);
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] g;

   always_comb begin
      logic carry;
      logic gen;
      p     = a ^ b;
      g     = a & b;
      carry = cin;
      gen   = 1'b0;
      sum   = '0;
      for (int unsigned i = 0; i < GROUP; i++) begin
         sum[i] = p[i] ^ carry;
         carry  = g[i] | (p[i] & carry);
         gen    = g[i] | (p[i] & gen);
      end
      p_out = &p;
      g_out = gen;
   end
endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead add/subtract with optional signed saturation.
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned GROUP  = 4,
   parameter bit          SAT_EN = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   input logic              flush,
   cla_addsub_pipe_if.slave bus
);
   localparam int unsigned      HALF    = WIDTH / 2;
   localparam int unsigned      NGRP    = HALF / GROUP;
   localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

   logic [WIDTH-1:0] b2;
   logic             cin;
   logic [HALF-1:0]  lo_sum;
   logic [HALF-1:0]  hi_sum;
   logic             mid_c;
   logic             hi_cout;

   logic             s1_valid_q, s1_valid_d;
   logic [HALF-1:0]  s1_lo_q, s1_lo_d;
   logic             s1_c_q, s1_c_d;
   logic [HALF-1:0]  s1_a_hi_q, s1_a_hi_d;
   logic [HALF-1:0]  s1_b2_hi_q, s1_b2_hi_d;
   op_e              s1_op_q, s1_op_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovfl_q, ovfl_d;
   logic             sat_q, sat_d;

   logic             s2_adv;
   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] raw;
   logic             raw_ovfl;
   logic             do_sat;
   logic [WIDTH-1:0] res;

   assign cin = bus.op[0];
   assign b2  = bus.op[0] ? ~bus.b : bus.b;

   // Lower half resolves in the accept cycle; its carry-out is registered as the mid carry.
   for (genvar k = 0; k < NGRP; k++) begin : g_lo
      logic ci, co, gp, gg;
      if (k == 0) begin : g_c0
         assign ci = cin;
      end else begin : g_cn
         assign ci = g_lo[k-1].co;
      end
      cla_group #(.GROUP(GROUP)) u_grp (
         .a     (bus.a[k*GROUP +: GROUP]),
         .b     (b2[k*GROUP +: GROUP]),
         .cin   (ci),
         .sum   (lo_sum[k*GROUP +: GROUP]),
         .p_out (gp),
         .g_out (gg)
      );
      assign co = gg | (gp & ci);
   end
   assign mid_c = g_lo[NGRP-1].co;

   for (genvar k = 0; k < NGRP; k++) begin : g_hi
      logic ci, co, gp, gg;
      if (k == 0) begin : g_c0
         assign ci = s1_c_q;
      end else begin : g_cn
         assign ci = g_hi[k-1].co;
      end
      cla_group #(.GROUP(GROUP)) u_grp (
         .a     (s1_a_hi_q[k*GROUP +: GROUP]),
         .b     (s1_b2_hi_q[k*GROUP +: GROUP]),
         .cin   (ci),
         .sum   (hi_sum[k*GROUP +: GROUP]),
         .p_out (gp),
         .g_out (gg)
      );
      assign co = gg | (gp & ci);
   end
   assign hi_cout = g_hi[NGRP-1].co;

   always_comb begin
      raw      = {hi_sum, s1_lo_q};
      raw_ovfl = (s1_a_hi_q[HALF-1] == s1_b2_hi_q[HALF-1]) &&
                 (raw[WIDTH-1] != s1_a_hi_q[HALF-1]);
      do_sat   = SAT_EN && raw_ovfl &&
                 ((s1_op_q == OP_ADD_SAT) || (s1_op_q == OP_SUB_SAT));
      res      = do_sat ? (s1_a_hi_q[HALF-1] ? SAT_MIN : SAT_MAX) : raw;
   end

   always_comb begin
      s2_adv   = !out_valid_q || bus.out_ready;
      in_ready = rst_n && !flush && (!s1_valid_q || s2_adv);
      accept   = bus.in_valid && in_ready;

      s1_valid_d = s1_valid_q;
      s1_lo_d    = s1_lo_q;
      s1_c_d     = s1_c_q;
      s1_a_hi_d  = s1_a_hi_q;
      s1_b2_hi_d = s1_b2_hi_q;
      s1_op_d    = s1_op_q;
      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (accept) begin
         s1_valid_d = 1'b1;
         s1_lo_d    = lo_sum;
         s1_c_d     = mid_c;
         s1_a_hi_d  = bus.a[WIDTH-1:HALF];
         s1_b2_hi_d = b2[WIDTH-1:HALF];
         s1_op_d    = op_e'(bus.op);
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovfl_d      = ovfl_q;
      sat_d       = sat_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            sum_d  = res;
            cout_d = hi_cout;
            ovfl_d = raw_ovfl;
            sat_d  = do_sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_lo_q     <= '0;
         s1_c_q      <= 1'b0;
         s1_a_hi_q   <= '0;
         s1_b2_hi_q  <= '0;
         s1_op_q     <= OP_ADD;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovfl_q      <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_lo_q     <= s1_lo_d;
         s1_c_q      <= s1_c_d;
         s1_a_hi_q   <= s1_a_hi_d;
         s1_b2_hi_q  <= s1_b2_hi_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovfl_q      <= ovfl_d;
         sat_q       <= sat_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovfl      = ovfl_q;
   assign bus.sat_flag  = sat_q;
endmodule
